// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI-lite response codes and the instruction-SRAM FSM encoding.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } isram_state_e;

endpackage

// File: rtl/ysyx_22050019_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used for stall injection.
module ysyx_22050019_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign out = lfsr_q;

  // rst_n is active-high here: the register holds SEED while it is 1.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

endmodule

// File: rtl/ysyx_22050019_isram.sv
// Read-only AXI-lite instruction SRAM with one outstanding read, configurable latency
// and optional pseudo-random extra delay; contents are preloaded through a side port.
module ysyx_22050019_isram
  import ysyx_22050019_axi_pkg::*;
#(
  parameter logic [63:0]  BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned  DEPTH_WORDS = 1024,
  parameter int unsigned  LATENCY     = 1,
  parameter bit           RAND_DELAY  = 1'b0,
  localparam int unsigned IdxW        = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     s_axi_araddr,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  input  logic            load_en,
  input  logic [IdxW-1:0] load_idx,
  input  logic [31:0]     load_data
);

  localparam logic [63:0] MemEnd = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd4;
  localparam int unsigned CntW   = 5;

  isram_state_e    state_q;
  logic [63:0]     addr_q;
  logic [63:0]     sel_addr;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_load;
  logic [IdxW-1:0] idx;
  logic [31:0]     dec_data;
  logic [1:0]      dec_resp;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            rvalid_q;
  logic [1:0]      extra;
  logic [7:0]      lfsr_out;
  logic            unused_lfsr;
  logic [31:0]     mem [DEPTH_WORDS];

  ysyx_22050019_lfsr8 #(
    .SEED (8'hA5)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr_out)
  );

  assign unused_lfsr = ^lfsr_out[7:2];
  assign extra       = RAND_DELAY ? lfsr_out[1:0] : 2'b00;
  assign cnt_load    = CntW'(LATENCY - 1) + CntW'(extra);

  // Data is latched on entry to RESP, which happens straight from IDLE when the
  // delay is zero, so decode the live address in that case.
  assign sel_addr = (state_q == StIdle) ? s_axi_araddr : addr_q;
  assign idx      = IdxW'((sel_addr - BASE_ADDR) >> 2);

  always_comb begin
    dec_resp = RESP_OKAY;
    dec_data = mem[idx];
    if (sel_addr[1:0] != 2'b00) begin
      dec_resp = RESP_SLVERR;
      dec_data = '0;
    end else if ((sel_addr < BASE_ADDR) || (sel_addr >= MemEnd)) begin
      dec_resp = RESP_DECERR;
      dec_data = '0;
    end
  end

  // Preload port is independent of the FSM; a read latched on the same edge sees old data.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axi_arvalid) begin
            addr_q <= s_axi_araddr;
            if (cnt_load != '0) begin
              cnt_q   <= cnt_load;
              state_q <= StWait;
            end else begin
              state_q  <= StResp;
              rvalid_q <= 1'b1;
              rdata_q  <= dec_data;
              rresp_q  <= dec_resp;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            state_q  <= StResp;
            rvalid_q <= 1'b1;
            rdata_q  <= dec_data;
            rresp_q  <= dec_resp;
          end
        end
        StResp: begin
          if (s_axi_rready) begin
            state_q  <= StIdle;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_arready = (state_q == StIdle) && !rst_n;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
